// File: rtl/vga_scan_gen_if.sv
// Pixel-side bundle of the VGA scan generator: framebuffer read port, pixel enable,
// test-pattern select and the DAC-facing colour/sync outputs.
interface vga_scan_gen_if #(
  parameter int ADDR_W  = 13,
  parameter int COLOR_W = 4
);
  logic               pix_en;
  logic               pattern_sel;
  logic [7:0]         pixel_data;
  logic [ADDR_W-1:0]  pixel_addr;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;

  modport master (
    input  pix_en, pattern_sel, pixel_data,
    output pixel_addr, red, green, blue, hsync, vsync, de, frame_start
  );

  modport slave (
    output pix_en, pattern_sel, pixel_data,
    input  pixel_addr, red, green, blue, hsync, vsync, de, frame_start
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Parametrised VGA raster generator: framebuffer addressing, read-latency-aligned de/sync
// and RGB332 expansion. Define VGA_TEST_PATTERN_EN to add the red/blue/green test pattern.
module vga_scan_gen #(
  parameter int H_DISP         = 640,
  parameter int H_FP           = 16,
  parameter int H_PW           = 96,
  parameter int H_TOT          = 800,
  parameter int V_DISP         = 480,
  parameter int V_FP           = 10,
  parameter int V_PW           = 2,
  parameter int V_TOT          = 525,
  parameter int SYNC_POL       = 0,
  parameter int SCALE_SHIFT    = 3,
  parameter int ADDR_W         = 13,
  parameter int RD_LAT         = 1,
  parameter int COLOR_W        = 4,
  parameter int PATTERN_FRAMES = 60
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_gen_if.master vif
);

  localparam int   HW       = $clog2(H_TOT);
  localparam int   VW       = $clog2(V_TOT);
  localparam int   DL       = RD_LAT + 1;
  localparam int   LINE_W   = H_DISP >> SCALE_SHIFT;
  localparam int   HS_START = H_DISP + H_FP;
  localparam int   HS_END   = HS_START + H_PW;
  localparam int   VS_START = V_DISP + V_FP;
  localparam int   VS_END   = VS_START + V_PW;
  localparam logic POL      = (SYNC_POL != 0);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  function automatic logic [COLOR_W-1:0] expand3(input logic [2:0] x);
    logic [COLOR_W-1:0] y;
    y = {COLOR_W{1'b0}};
    for (int i = 0; i < COLOR_W; i++) y[COLOR_W-1-i] = x[2-(i%3)];
    return y;
  endfunction

  function automatic logic [COLOR_W-1:0] expand2(input logic [1:0] x);
    logic [COLOR_W-1:0] y;
    y = {COLOR_W{1'b0}};
    for (int i = 0; i < COLOR_W; i++) y[COLOR_W-1-i] = x[1-(i%2)];
    return y;
  endfunction

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DL-1:0]     de_dl_q, de_dl_d, hs_dl_q, hs_dl_d, vs_dl_q, vs_dl_d;
  logic              fs_q, fs_d;
  logic [31:0]       h32_s, v32_s;
  logic              active_s, hs_raw_s, vs_raw_s, de_out_s;
  logic [COLOR_W-1:0] red_s, green_s, blue_s;

  assign h32_s = 32'(h_q);
  assign v32_s = 32'(v_q);

  // Raw (undelayed) timing flags for the position currently held in the counters.
  always_comb begin
    active_s = (h32_s < H_DISP) && (v32_s < V_DISP);
    hs_raw_s = (h32_s >= HS_START) && (h32_s < HS_END);
    vs_raw_s = (v32_s >= VS_START) && (v32_s < VS_END);
  end

  // Counters, address stage and delay lines advance only on pix_en ticks.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    addr_d  = addr_q;
    de_dl_d = de_dl_q;
    hs_dl_d = hs_dl_q;
    vs_dl_d = vs_dl_q;
    fs_d    = 1'b0;
    if (vif.pix_en) begin
      addr_d  = active_s ? ADDR_W'(32'(v_q >> SCALE_SHIFT) * LINE_W + 32'(h_q >> SCALE_SHIFT))
                         : {ADDR_W{1'b0}};
      de_dl_d = {de_dl_q[DL-2:0], active_s};
      hs_dl_d = {hs_dl_q[DL-2:0], hs_raw_s};
      vs_dl_d = {vs_dl_q[DL-2:0], vs_raw_s};
      if (h32_s == H_TOT - 1) begin
        h_d = {HW{1'b0}};
        if (v32_s == V_TOT - 1) begin
          v_d  = {VW{1'b0}};
          fs_d = 1'b1;
        end else begin
          v_d = v_q + VW'(1'b1);
        end
      end else begin
        h_d = h_q + HW'(1'b1);
      end
    end else begin
      fs_d = 1'b0;
    end
  end

  // Timing state; sync delay stages hold "asserted" flags, so clearing them means inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= {HW{1'b0}};
      v_q     <= {VW{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      de_dl_q <= {DL{1'b0}};
      hs_dl_q <= {DL{1'b0}};
      vs_dl_q <= {DL{1'b0}};
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      de_dl_q <= de_dl_d;
      hs_dl_q <= hs_dl_d;
      vs_dl_q <= vs_dl_d;
      fs_q    <= fs_d;
    end
  end

  assign de_out_s = de_dl_q[DL-1];

`ifdef VGA_TEST_PATTERN_EN
  localparam int FW = $clog2(PATTERN_FRAMES + 1);
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]    pat_q, pat_d;

  // Pattern colour index steps red -> blue -> green every PATTERN_FRAMES frames.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    if (fs_q) begin
      if (32'(frame_cnt_q) == PATTERN_FRAMES - 1) begin
        frame_cnt_d = {FW{1'b0}};
        pat_d       = (pat_q == 2'd2) ? 2'd0 : pat_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1'b1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= {FW{1'b0}};
      pat_q       <= 2'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
    end
  end
`else
  logic unused_pattern_sel_s;
  assign unused_pattern_sel_s = vif.pattern_sel;
`endif

  // Colour follows pixel_data directly: the RAM data already lines up with the delayed de.
  always_comb begin
    red_s   = {COLOR_W{1'b0}};
    green_s = {COLOR_W{1'b0}};
    blue_s  = {COLOR_W{1'b0}};
    if (de_out_s) begin
`ifdef VGA_TEST_PATTERN_EN
      if (vif.pattern_sel) begin
        case (pat_q)
          2'd0:    red_s   = FULL;
          2'd1:    blue_s  = FULL;
          2'd2:    green_s = FULL;
          default: red_s   = {COLOR_W{1'b0}};
        endcase
      end else begin
        red_s   = expand3(vif.pixel_data[7:5]);
        green_s = expand3(vif.pixel_data[4:2]);
        blue_s  = expand2(vif.pixel_data[1:0]);
      end
`else
      red_s   = expand3(vif.pixel_data[7:5]);
      green_s = expand3(vif.pixel_data[4:2]);
      blue_s  = expand2(vif.pixel_data[1:0]);
`endif
    end else begin
      red_s = {COLOR_W{1'b0}};
    end
  end

  assign vif.pixel_addr  = addr_q;
  assign vif.de          = de_out_s;
  assign vif.hsync       = hs_dl_q[DL-1] ? POL : ~POL;
  assign vif.vsync       = vs_dl_q[DL-1] ? POL : ~POL;
  assign vif.frame_start = fs_q;
  assign vif.red         = red_s;
  assign vif.green       = green_s;
  assign vif.blue        = blue_s;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a shrunken 24x12 raster (16x8 visible, scale 4, RD_LAT 2);
// RAM model returns pixel_addr ^ 8'hE3 with RD_LAT pix_en ticks of latency.
module tb_vga_scan_gen;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   n = 0;
  int   div = 1;
  int   clk_cnt = 0;
  int   c0 = 0;
  logic [7:0] ram1_q, ram2_q;

  vga_scan_gen_if #(.ADDR_W(8), .COLOR_W(4)) vif ();

  vga_scan_gen #(
    .H_DISP(16), .H_FP(2), .H_PW(3), .H_TOT(24),
    .V_DISP(8), .V_FP(1), .V_PW(2), .V_TOT(12),
    .SYNC_POL(0), .SCALE_SHIFT(2), .ADDR_W(8), .RD_LAT(2),
    .COLOR_W(4), .PATTERN_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Framebuffer RAM model with two-tick read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram1_q <= 8'h00;
      ram2_q <= 8'h00;
    end else if (vif.pix_en) begin
      ram1_q <= vif.pixel_addr ^ 8'hE3;
      ram2_q <= ram1_q;
    end
  end
  assign vif.pixel_data = ram2_q;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick_edge();
    vif.pix_en = 1'b1;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle(input int k);
    vif.pix_en = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    tick_edge();
    if (div > 1) idle(div - 1);
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.pix_en = 1'b0;
    vif.pattern_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vif.pixel_addr !== 8'h00) $display("FAIL rst_addr: got %h want %h", vif.pixel_addr, 8'h00); else passed++;
    checks++; if (vif.de !== 1'b0) $display("FAIL rst_de: got %b want %b", vif.de, 1'b0); else passed++;
    checks++; if (vif.red !== 4'h0 || vif.green !== 4'h0 || vif.blue !== 4'h0) $display("FAIL rst_rgb: got %h%h%h want 000", vif.red, vif.green, vif.blue); else passed++;
    checks++; if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) $display("FAIL rst_sync: got %b%b want 11", vif.hsync, vif.vsync); else passed++;
    checks++; if (vif.frame_start !== 1'b0) $display("FAIL rst_fs: got %b want %b", vif.frame_start, 1'b0); else passed++;
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_latency();
    run_to(2);
    checks++; if (vif.de !== 1'b0) $display("FAIL lat_de_early: got %b want %b", vif.de, 1'b0); else passed++;
    checks++; if (vif.red !== 4'h0) $display("FAIL lat_red_early: got %h want %h", vif.red, 4'h0); else passed++;
    run_to(3);
    checks++; if (vif.de !== 1'b1) $display("FAIL lat_de_rise: got %b want %b", vif.de, 1'b1); else passed++;
    checks++; if (vif.red !== 4'hF || vif.green !== 4'h0 || vif.blue !== 4'hF) $display("FAIL lat_rgb_e3: got %h%h%h want F0F", vif.red, vif.green, vif.blue); else passed++;
    run_to(5);
    checks++; if (vif.pixel_addr !== 8'h01) $display("FAIL lat_addr_h4: got %h want %h", vif.pixel_addr, 8'h01); else passed++;
    run_to(7);
    checks++; if (vif.blue !== 4'hA || vif.red !== 4'hF) $display("FAIL lat_rgb_e2: got r%h b%h want rF bA", vif.red, vif.blue); else passed++;
  endtask

  task automatic test_hsync_line();
    run_to(18);
    checks++; if (vif.de !== 1'b1) $display("FAIL line_de_h15: got %b want %b", vif.de, 1'b1); else passed++;
    run_to(19);
    checks++; if (vif.de !== 1'b0 || vif.red !== 4'h0) $display("FAIL line_blank_h16: got de%b r%h want de0 r0", vif.de, vif.red); else passed++;
    run_to(20);
    checks++; if (vif.hsync !== 1'b1) $display("FAIL hs_h17: got %b want %b", vif.hsync, 1'b1); else passed++;
    run_to(21);
    checks++; if (vif.hsync !== 1'b0) $display("FAIL hs_h18: got %b want %b", vif.hsync, 1'b0); else passed++;
    run_to(23);
    checks++; if (vif.hsync !== 1'b0) $display("FAIL hs_h20: got %b want %b", vif.hsync, 1'b0); else passed++;
    run_to(24);
    checks++; if (vif.hsync !== 1'b1) $display("FAIL hs_h21: got %b want %b", vif.hsync, 1'b1); else passed++;
    run_to(26);
    checks++; if (vif.de !== 1'b0) $display("FAIL line_de_h23: got %b want %b", vif.de, 1'b0); else passed++;
    run_to(27);
    checks++; if (vif.de !== 1'b1) $display("FAIL line_de_l1: got %b want %b", vif.de, 1'b1); else passed++;
    run_to(44);
    checks++; if (vif.hsync !== 1'b1) $display("FAIL hs_l1_h17: got %b want %b", vif.hsync, 1'b1); else passed++;
    run_to(45);
    checks++; if (vif.hsync !== 1'b0) $display("FAIL hs_l1_h18: got %b want %b", vif.hsync, 1'b0); else passed++;
  endtask

  task automatic test_address();
    run_to(130);
    checks++; if (vif.pixel_addr !== 8'h06) $display("FAIL addr_l5_h9: got %h want %h", vif.pixel_addr, 8'h06); else passed++;
    run_to(132);
    checks++; if (vif.green !== 4'h2 || vif.blue !== 4'h5) $display("FAIL rgb_e5: got g%h b%h want g2 b5", vif.green, vif.blue); else passed++;
    run_to(136);
    checks++; if (vif.pixel_addr !== 8'h07) $display("FAIL addr_l5_h15: got %h want %h", vif.pixel_addr, 8'h07); else passed++;
    run_to(137);
    checks++; if (vif.pixel_addr !== 8'h00) $display("FAIL addr_l5_h16: got %h want %h", vif.pixel_addr, 8'h00); else passed++;
    run_to(184);
    checks++; if (vif.pixel_addr !== 8'h07) $display("FAIL addr_l7_h15: got %h want %h", vif.pixel_addr, 8'h07); else passed++;
    run_to(193);
    checks++; if (vif.pixel_addr !== 8'h00) $display("FAIL addr_l8_h0: got %h want %h", vif.pixel_addr, 8'h00); else passed++;
    run_to(195);
    checks++; if (vif.de !== 1'b0) $display("FAIL de_l8_h0: got %b want %b", vif.de, 1'b0); else passed++;
  endtask

  task automatic test_vsync();
    run_to(218);
    checks++; if (vif.vsync !== 1'b1) $display("FAIL vs_l8: got %b want %b", vif.vsync, 1'b1); else passed++;
    run_to(219);
    checks++; if (vif.vsync !== 1'b0) $display("FAIL vs_l9: got %b want %b", vif.vsync, 1'b0); else passed++;
    run_to(266);
    checks++; if (vif.vsync !== 1'b0) $display("FAIL vs_l10: got %b want %b", vif.vsync, 1'b0); else passed++;
    run_to(267);
    checks++; if (vif.vsync !== 1'b1) $display("FAIL vs_l11: got %b want %b", vif.vsync, 1'b1); else passed++;
  endtask

  task automatic test_frame_start();
    run_to(287);
    checks++; if (vif.frame_start !== 1'b0) $display("FAIL fs_before: got %b want %b", vif.frame_start, 1'b0); else passed++;
    run_to(288);
    checks++; if (vif.frame_start !== 1'b1) $display("FAIL fs_wrap: got %b want %b", vif.frame_start, 1'b1); else passed++;
    run_to(289);
    checks++; if (vif.frame_start !== 1'b0) $display("FAIL fs_after: got %b want %b", vif.frame_start, 1'b0); else passed++;
    run_to(290);
    checks++; if (vif.de !== 1'b0) $display("FAIL f1_de_early: got %b want %b", vif.de, 1'b0); else passed++;
    run_to(291);
    checks++; if (vif.de !== 1'b1) $display("FAIL f1_de_rise: got %b want %b", vif.de, 1'b1); else passed++;
    run_to(576);
    checks++; if (vif.frame_start !== 1'b1) $display("FAIL fs_frame2: got %b want %b", vif.frame_start, 1'b1); else passed++;
  endtask

  task automatic test_slow_enable();
    div = 4;
    run_to(580);
    checks++; if (vif.pixel_addr !== 8'h00) $display("FAIL slow_addr_h3: got %h want %h", vif.pixel_addr, 8'h00); else passed++;
    tick_edge();
    for (int i = 0; i < 4; i++) begin
      checks++; if (vif.pixel_addr !== 8'h01) $display("FAIL slow_addr_hold%0d: got %h want %h", i, vif.pixel_addr, 8'h01); else passed++;
      if (i < 3) idle(1);
    end
    run_to(596);
    tick_edge();
    c0 = clk_cnt;
    for (int i = 0; i < 4; i++) begin
      checks++; if (vif.hsync !== 1'b0) $display("FAIL slow_hs_hold%0d: got %b want %b", i, vif.hsync, 1'b0); else passed++;
      if (i < 3) idle(1);
    end
    run_to(620);
    checks++; if (vif.hsync !== 1'b1) $display("FAIL slow_hs_l1_h17: got %b want %b", vif.hsync, 1'b1); else passed++;
    tick_edge();
    checks++; if (vif.hsync !== 1'b0 || clk_cnt - c0 !== 96) $display("FAIL slow_line_period: got hs%b %0d clks want hs0 96 clks", vif.hsync, clk_cnt - c0); else passed++;
    idle(3);
    run_to(863);
    tick_edge();
    checks++; if (vif.frame_start !== 1'b1) $display("FAIL slow_fs_high: got %b want %b", vif.frame_start, 1'b1); else passed++;
    idle(1);
    checks++; if (vif.frame_start !== 1'b0) $display("FAIL slow_fs_width: got %b want %b", vif.frame_start, 1'b0); else passed++;
    idle(2);
    checks++; if (vif.frame_start !== 1'b0) $display("FAIL slow_fs_idle: got %b want %b", vif.frame_start, 1'b0); else passed++;
    div = 1;
  endtask

  task automatic test_reset_midframe();
    run_to(995);
    checks++; if (vif.de !== 1'b1 || vif.pixel_addr !== 8'h06) $display("FAIL mid_before: got de%b a%h want de1 a06", vif.de, vif.pixel_addr); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (vif.pixel_addr !== 8'h00 || vif.de !== 1'b0) $display("FAIL mid_rst_now: got a%h de%b want a00 de0", vif.pixel_addr, vif.de); else passed++;
    checks++; if (vif.red !== 4'h0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1) $display("FAIL mid_rst_out: got r%h hs%b vs%b want r0 hs1 vs1", vif.red, vif.hsync, vif.vsync); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vif.de !== 1'b0 || vif.pixel_addr !== 8'h00 || vif.frame_start !== 1'b0) $display("FAIL mid_rst_hold: got de%b a%h fs%b want 0 00 0", vif.de, vif.pixel_addr, vif.frame_start); else passed++;
    rst = 1'b0;
    n = 0;
    run_to(2);
    checks++; if (vif.de !== 1'b0) $display("FAIL mid_de_early: got %b want %b", vif.de, 1'b0); else passed++;
    run_to(3);
    checks++; if (vif.de !== 1'b1 || vif.vsync !== 1'b1) $display("FAIL mid_restart: got de%b vs%b want de1 vs1", vif.de, vif.vsync); else passed++;
    checks++; if (vif.red !== 4'hF || vif.blue !== 4'hF) $display("FAIL mid_rgb: got r%h b%h want rF bF", vif.red, vif.blue); else passed++;
  endtask

  task automatic test_pattern();
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0] exp_r [7] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] exp_g [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
    logic [3:0] exp_b [7] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    vif.pattern_sel = 1'b1;
    for (int k = 0; k < 7; k++) begin
      run_to(288 * k + 4);
      checks++; if (vif.red !== exp_r[k] || vif.green !== exp_g[k] || vif.blue !== exp_b[k]) $display("FAIL pat_frame%0d: got %h%h%h want %h%h%h", k, vif.red, vif.green, vif.blue, exp_r[k], exp_g[k], exp_b[k]); else passed++;
      run_to(288 * k + 20);
      checks++; if (vif.red !== 4'h0 || vif.green !== 4'h0 || vif.blue !== 4'h0) $display("FAIL pat_blank%0d: got %h%h%h want 000", k, vif.red, vif.green, vif.blue); else passed++;
    end
`else
    vif.pattern_sel = 1'b1;
    run_to(4);
    checks++; if (vif.red !== 4'hF || vif.green !== 4'h0 || vif.blue !== 4'hF) $display("FAIL pat_ignored: got %h%h%h want F0F", vif.red, vif.green, vif.blue); else passed++;
`endif
    vif.pattern_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hsync_line();
    test_address();
    test_vsync();
    test_frame_start();
    test_slow_enable();
    test_reset_midframe();
    test_pattern();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Parametrised VGA raster generator with framebuffer address generation, read-latency compensation and RGB332 colour expansion. Sits between the frame-buffer RAM (8-bit RGB332 pixels, down-scaled by a power of two) and the VGA DAC pins. It supersedes the fixed 640x480 generator: timing, sync polarity, scale, RAM latency and colour depth are all parameters, and it adds a data-enable output and a frame-start strobe.

## Interface
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_PW, 96, hsync pulse width
- H_TOT, 800, total pixels per line
- V_DISP, 480, visible lines
- V_FP, 10, vertical front porch
- V_PW, 2, vsync pulse width
- V_TOT, 525, total lines per frame
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- SCALE_SHIFT, 3, each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- ADDR_W, 13, framebuffer address width
- RD_LAT, 1, framebuffer read latency in pix_en ticks (>=1)
- COLOR_W, 4, bits per colour channel (>=3)
- PATTERN_FRAMES, 60, frames per test-pattern colour

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate enable; the block advances only on clk edges with pix_en=1
- pattern_sel  in  1  select test pattern instead of framebuffer (see Configuration)
- pixel_data  in  8  RGB332 from RAM {r[2:0],g[2:0],b[1:0]}, valid RD_LAT ticks after pixel_addr
- pixel_addr  out  ADDR_W  framebuffer read address
- red, green, blue  out  COLOR_W each  DAC colour
- hsync, vsync  out  1  sync outputs
- de  out  1  display enable, aligned with colour
- frame_start  out  1  one-clk strobe at start of each frame

## Operation
- hcount 0..H_TOT-1, vcount 0..V_TOT-1; hcount wraps to 0 and vcount increments; at (H_TOT-1, V_TOT-1) both wrap to 0.
- Active region: hcount<H_DISP and vcount<V_DISP.
- Address stage: in active region pixel_addr = (vcount>>SCALE_SHIFT)*(H_DISP>>SCALE_SHIFT) + (hcount>>SCALE_SHIFT), truncated to ADDR_W; outside the active region pixel_addr=0. Registered.
- Raw sync: hsync asserted for H_DISP+H_FP <= hcount < H_DISP+H_FP+H_PW; vsync for V_DISP+V_FP <= vcount < V_DISP+V_FP+V_PW (whole lines, independent of hcount). Asserted level = SYNC_POL.
- Raw de, hsync, vsync pass through a delay line of RD_LAT+1 pix_en ticks so they align with colour.
- Colour expansion: each channel left-justified and bit-replicated to COLOR_W (r=3'b101, COLOR_W=4 -> 4'b1011; b=2'b10 -> 4'b1010).
- When delayed de=0, red/green/blue = 0.
- Parameter legality (H_DISP+H_FP+H_PW <= H_TOT, likewise vertical; address fits ADDR_W) is the integrator's responsibility; no runtime check.

## Timing
- Reset (async): counters 0, pixel_addr 0, colours 0, de 0, hsync/vsync = ~SYNC_POL, frame_start 0, delay line filled with blanking, frame counter 0.
- First pix_en tick after reset release processes position (0,0).
- pix_en=0: all state and outputs hold; frame_start is low.
- Latency: pixel_addr for a position appears 1 tick after that position; colour/de/hsync/vsync for it appear RD_LAT+1 ticks after.
- frame_start: high for exactly one clk, on the clk following the pix_en edge that wraps the counters to (0,0); not delayed.
- Reset mid-frame: immediate clear; the frame restarts at (0,0) with no partial-line outputs.

## Configuration
- VGA_TEST_PATTERN_EN defined: with pattern_sel=1, active-region colour is solid red, then blue, then green (full scale on one channel), advancing every PATTERN_FRAMES frames and cycling; pixel_data is ignored, but pixel_addr is still generated. Frame counter advances on frame_start; pattern_sel changes take effect at next active pixel.
- Not defined: pattern_sel is ignored, no frame/pattern counters synthesised; colour always from pixel_data.

## Test plan
- Defaults, pix_en every clk, 2 frames -> hsync low for 96 clks starting hcount 656, vsync low on lines 490-491, line period 800, frame period 420000 clks.
- Address: SCALE_SHIFT=3, line 9, hcount 17 -> pixel_addr = 1*80+2 = 82; hcount 640 -> pixel_addr 0.
- RD_LAT=2, RAM model returning addr[7:0] -> colour of pixel (0,0) and de rise appear 3 ticks after (0,0); pixel_data 8'hE3 -> red=4'hF, green=0, blue=4'hF.
- pix_en=1 every 4th clk -> all timings scale x4; outputs stable between enables; frame_start one clk wide.
- Assert rst at (300,200) for 3 clks -> outputs reset values immediately; after release, first de rise 2 ticks after restart (RD_LAT=1), vsync inactive.
- VGA_TEST_PATTERN_EN, PATTERN_FRAMES=2, pattern_sel=1 -> frames 0-1 red=4'hF only, 2-3 blue, 4-5 green, frame 6 red again; blanking colour 0.
